id_ex_hazard_reg: RTL

//  ID/EX pipeline register with load-use hazard detection, sitting between decode and the EX stage.
//  - Captures decoded operands and controls from ID.
//  - Inserts a one-cycle bubble on a load-use hazard or a branch flush.
//  - Drives RS/RT/dest register numbers to the EX-stage forwarding logic and the EX/MEM register.
//  - Drives the stall that freezes the PC and the IF/ID register.

---
 rtl/id_ex_hazard_reg.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures decoded operands/controls from ID and presents them to EX one
// cycle later. A bubble is loaded instead when a branch/jump resolved in EX
// squashes the ID instruction (flush) or when the ID instruction reads the
// register that a load currently in EX is about to write (load-use stall).
//
// Slot semantics: EX_valid=1 means the EX_* fields describe a real
// instruction; EX_valid=0 means a bubble, and every EX_* field is then zero
// (dest 0 can only match reg $0, which consumers ignore). stall is a
// combinational request to the upstream stages: while it is 1 the PC and
// IF/ID hold, so the same ID inputs are presented again on the next cycle.
module id_ex_hazard_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] IF_ID_RS,
  input  logic [REG_AW-1:0] IF_ID_RT,
  input  logic [REG_AW-1:0] IF_ID_RD,
  input  logic              ID_uses_rs,
  input  logic              ID_uses_rt,
  input  logic [DATA_W-1:0] ID_rs_data,
  input  logic [DATA_W-1:0] ID_rt_data,
  input  logic [DATA_W-1:0] ID_imm,
  input  logic [7:0]        ID_ctrl,
  input  logic              flush,
  output logic              stall,
  output logic              EX_valid,
  output logic [REG_AW-1:0] EX_RS,
  output logic [REG_AW-1:0] EX_RT,
  output logic [REG_AW-1:0] EX_dest_reg,
  output logic [DATA_W-1:0] EX_rs_data,
  output logic [DATA_W-1:0] EX_rt_data,
  output logic [DATA_W-1:0] EX_imm,
  output logic [7:0]        EX_ctrl,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  // Control-byte layout: {reg_dst, alu_src, mem_read, mem_write,
  //                       reg_write, mem_to_reg, alu_op[1:0]}
  localparam int CTRL_REG_DST  = 7;
  localparam int CTRL_MEM_READ = 5;

  logic              ex_valid_q,   ex_valid_d;
  logic [REG_AW-1:0] ex_rs_q,      ex_rs_d;
  logic [REG_AW-1:0] ex_rt_q,      ex_rt_d;
  logic [REG_AW-1:0] ex_dest_q,    ex_dest_d;
  logic [DATA_W-1:0] ex_rs_data_q, ex_rs_data_d;
  logic [DATA_W-1:0] ex_rt_data_q, ex_rt_data_d;
  logic [DATA_W-1:0] ex_imm_q,     ex_imm_d;
  logic [7:0]        ex_ctrl_q,    ex_ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q,  flush_cnt_d;

  logic ex_is_load;
  logic rs_match;
  logic rt_match;
  logic haz;
  logic load_bubble;

  // Load-use detection against the instruction currently held in EX.
  always_comb begin
    ex_is_load = ex_valid_q && ex_ctrl_q[CTRL_MEM_READ] && (ex_dest_q != '0);
    rs_match   = ID_uses_rs && (IF_ID_RS == ex_dest_q);
    rt_match   = ID_uses_rt && (IF_ID_RT == ex_dest_q);
    haz        = ex_is_load && (rs_match || rt_match);
  end

  // A squashed ID instruction never needs to wait, so flush masks the stall.
  assign stall       = haz && !flush;
  assign load_bubble = flush || haz;

  // Next slot contents: bubble on flush/stall, otherwise the ID instruction.
  always_comb begin
    ex_valid_d   = 1'b0;
    ex_rs_d      = '0;
    ex_rt_d      = '0;
    ex_dest_d    = '0;
    ex_rs_data_d = '0;
    ex_rt_data_d = '0;
    ex_imm_d     = '0;
    ex_ctrl_d    = '0;
    if (!load_bubble) begin
      ex_valid_d   = 1'b1;
      ex_rs_d      = IF_ID_RS;
      ex_rt_d      = IF_ID_RT;
      ex_dest_d    = ID_ctrl[CTRL_REG_DST] ? IF_ID_RD : IF_ID_RT;
      ex_rs_data_d = ID_rs_data;
      ex_rt_data_d = ID_rt_data;
      ex_imm_d     = ID_imm;
      ex_ctrl_d    = ID_ctrl;
    end
  end

  // Saturating performance counters; flush has priority over stall.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (flush) begin
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (stall) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Pipeline register and counters, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_dest_q    <= '0;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
      ex_imm_q     <= '0;
      ex_ctrl_q    <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_dest_q    <= ex_dest_d;
      ex_rs_data_q <= ex_rs_data_d;
      ex_rt_data_q <= ex_rt_data_d;
      ex_imm_q     <= ex_imm_d;
      ex_ctrl_q    <= ex_ctrl_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign EX_valid    = ex_valid_q;
  assign EX_RS       = ex_rs_q;
  assign EX_RT       = ex_rt_q;
  assign EX_dest_reg = ex_dest_q;
  assign EX_rs_data  = ex_rs_data_q;
  assign EX_rt_data  = ex_rt_data_q;
  assign EX_imm      = ex_imm_q;
  assign EX_ctrl     = ex_ctrl_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule
